affine_loop_controller: RTL and testbench
=========================================

# affine_loop_controller

Schedule-driven loop-nest controller that sits directly upstream of each generated unified buffer port. It walks a DIMS-deep affine iteration domain and asserts a one-cycle valid pulse at each scheduled cycle, with the current loop indices on `ctrl_vars`. The pulse drives the buffer's `*_write_wen` / `*_read_ren`, and `ctrl_vars` drives its `*_ctrl_vars` bus, from which the buffer derives bank select and address.

## Interface
- `DIMS`, default 3: loop depth; index 0 is outermost, index DIMS-1 is innermost.
- `IW`, default 16: width of each index and extent.
- `TW`, default 32: width of the cycle counter and of the schedule terms.
- `clk`  input  1: the single clock.
- `rst_n`  input  1: reset, asynchronous and active-low.
- `flush`  input  1: synchronous restart; in any state it returns all counters to their start values.
- `extent`  input  IW x DIMS: trip count per dimension; a value of 0 is treated as 1.
- `sched_stride`  input  TW x DIMS: cycles added to the schedule per unit step of each index.
- `sched_start`  input  TW: scheduled cycle of iteration (0,…,0).
- `valid`  output  1: fire pulse (wen/ren to the buffer).
- `ctrl_vars`  output  IW x DIMS: current loop indices.
- `done`  output  1: iteration domain is exhausted.
- `sched_err`  output  1: sticky flag; a scheduled cycle was missed.

## Operation
- **Config stability:** `extent`, `sched_stride` and `sched_start` must be stable from the flush edge until `done`. Behaviour is unspecified if they change earlier.
- **States:** IDLE, RUN, DONE.
  - Reset puts the block in IDLE.
  - `flush` sampled high moves the block to RUN from any state.
  - RUN moves to DONE after the last fire, or on an error.
  - DONE holds until the next `flush`.
- **Registers:**
  - `cyc` (TW bits).
  - `idx[DIMS]`.
  - `next_t` (TW bits) = `sched_start` + Σ `idx[d]`·`sched_stride[d]`, mod 2^TW, products truncated to TW bits.
  - `next_t` is held in a register and recomputed or updated incrementally whenever `idx` changes. It must equal the formula at every cycle in RUN.
- **Fire:** `valid` = (state == RUN) && (`cyc` == `next_t`). It is decoded combinationally from registers only and has no combinational path from any input.
- **On a fire edge:**
  - The innermost index increments.
  - Any index at `extent`−1 wraps to 0 and carries into the next-outer index (odometer order).
  - If every index was at `extent`−1, the indices are not changed; the state goes to DONE and `done` rises.
- **Cycle counter:** `cyc` increments by 1 every cycle in RUN and wraps at 2^TW. It holds in IDLE and DONE.
- **Missed schedule:** if in RUN `cyc` > `next_t` (unsigned compare), `sched_err` sets, the state goes to DONE and `done` rises. This happens for a non-increasing schedule, e.g. a stride of 0 on a dimension with extent > 1.
- **Flush effect:** `flush` clears `cyc`, `idx`, `done` and `sched_err`, and sets `next_t` = `sched_start`.
- **Flush coinciding with a fire:** the pulse on that cycle is still presented (the downstream write happens); the restart takes effect after the edge.
- **Flush in IDLE:** a flush is required to leave IDLE; `valid` never fires in IDLE.

## Timing
- **Reset values:** `valid`=0, `ctrl_vars`=0, `done`=0, `sched_err`=0; state IDLE; `cyc`=0.
- **Cycle numbering:**
  - The cycle after the flush edge is cycle 0, with `cyc`=0.
  - Iteration i fires during cycle `next_t(i)`.
  - With `sched_start`=0, `valid` is high in the very first cycle after the flush edge.
- **Output alignment:** `ctrl_vars` shows the indices of the fire in the same cycle `valid` is high (zero latency). It updates on the edge that ends the fire.
- **Done timing:**
  - `done` rises on the edge that ends the final fire, and stays high until `flush` or reset.
  - In DONE, `ctrl_vars` holds the final indices (all `extent`−1).
- **Back-to-back fires:** consecutive schedule times (stride-1 innermost) produce `valid` high on consecutive cycles with no bubble.
- **Asynchronous reset mid-RUN:** returns to IDLE immediately; `valid` drops asynchronously.
- **Reset vs. flush:** reset has priority over flush.

## Test plan
1. **Nominal nest:** DIMS=3, extent={1,4,3}, stride={0,3,1}, start=5, flush → `valid` high in cycles 5..16 (12 pulses) with `ctrl_vars` stepping (0,0,0),(0,0,1),(0,0,2),(0,1,0)…(0,3,2); `done` rises at cycle 17; `sched_err`=0.
2. **Gapped schedule:** extent={1,2,2}, stride={0,10,2}, start=0 → pulses at cycles 0, 2, 10, 12 only; `valid` low in every other cycle.
3. **Missed schedule:** extent={1,1,3}, stride={0,0,0} → one pulse at cycle 0; at cycle 1 `sched_err`=1 and `done`=1; no further pulses.
4. **Flush mid-run:** run scenario 1 and assert flush at cycle 9 → the pulse at cycle 9 is still seen; the next pulse is at new cycle 5 with `ctrl_vars`=(0,0,0); the full count of 12 pulses completes.
5. **Reset mid-run:** assert `rst_n` low at cycle 8 of scenario 1 → all outputs 0 at once; no `valid` until a flush after reset release.
6. **Degenerate extent:** extent={0,0,0}, start=3 → exactly one pulse at cycle 3 with `ctrl_vars`=(0,0,0); `done` rises at cycle 4.

Source files
------------

// File: rtl/affine_loop_controller.sv
// Affine loop-nest controller: walks a DIMS-deep odometer and pulses valid_o
// whenever the free-running cycle counter reaches the affine schedule time.
module affine_loop_controller #(
    parameter int DIMS = 3,
    parameter int IW   = 16,
    parameter int TW   = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic [DIMS-1:0][IW-1:0]  extent_i,
    input  logic [DIMS-1:0][TW-1:0]  sched_stride_i,
    input  logic [TW-1:0]            sched_start_i,
    output logic                     valid_o,
    output logic [DIMS-1:0][IW-1:0]  ctrl_vars_o,
    output logic                     done_o,
    output logic                     sched_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [IW-1:0] IDX_ONE = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] CYC_ONE = {{(TW-1){1'b0}}, 1'b1};

    // A zero trip count behaves as a single iteration.
    function automatic logic [IW-1:0] eff_extent(input logic [IW-1:0] e);
        if (e == {IW{1'b0}}) begin
            return IDX_ONE;
        end else begin
            return e;
        end
    endfunction

    // Schedule time of an index vector, modulo 2^TW.
    function automatic logic [TW-1:0] sched_time(
        input logic [DIMS-1:0][IW-1:0] idx,
        input logic [DIMS-1:0][TW-1:0] stride,
        input logic [TW-1:0]           start
    );
        logic [TW-1:0] acc;
        acc = start;
        for (int d = 0; d < DIMS; d++) begin
            acc = acc + (TW'(idx[d]) * stride[d]);
        end
        return acc;
    endfunction

    state_e                    state_q, state_d;
    logic [TW-1:0]             cyc_q, cyc_d;
    logic [DIMS-1:0][IW-1:0]   idx_q, idx_d;
    logic [TW-1:0]             next_t_q, next_t_d;
    logic                      err_q, err_d;

    logic                      fire_s;
    logic                      carry_s;
    logic                      last_s;
    logic [DIMS-1:0][IW-1:0]   idx_step_s;
    logic [TW-1:0]             next_t_step_s;
    logic [TW-1:0]             cyc_inc_s;
    logic [TW-1:0]             t_cand_s;

    assign fire_s        = (state_q == ST_RUN) && (cyc_q == next_t_q);
    assign cyc_inc_s     = cyc_q + CYC_ONE;
    assign next_t_step_s = sched_time(idx_step_s, sched_stride_i, sched_start_i);
    assign t_cand_s      = fire_s ? next_t_step_s : next_t_q;

    // Odometer step: innermost index increments, saturated digits wrap and carry outward.
    always_comb begin
        carry_s    = 1'b1;
        idx_step_s = idx_q;
        for (int d = DIMS - 1; d >= 0; d--) begin
            if (carry_s) begin
                if (idx_q[d] == (eff_extent(extent_i[d]) - IDX_ONE)) begin
                    idx_step_s[d] = {IW{1'b0}};
                end else begin
                    idx_step_s[d] = idx_q[d] + IDX_ONE;
                    carry_s       = 1'b0;
                end
            end else begin
                idx_step_s[d] = idx_q[d];
            end
        end
        last_s = carry_s;
    end

    // Next-state logic for the controller FSM and its datapath registers.
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        idx_d    = idx_q;
        next_t_d = next_t_q;
        err_d    = err_q;
        if (flush_i) begin
            state_d  = ST_RUN;
            cyc_d    = {TW{1'b0}};
            idx_d    = '0;
            next_t_d = sched_start_i;
            err_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_RUN: begin
                    cyc_d = cyc_inc_s;
                    if (fire_s && !last_s) begin
                        idx_d    = idx_step_s;
                        next_t_d = next_t_step_s;
                    end else begin
                        idx_d    = idx_q;
                        next_t_d = next_t_q;
                    end
                    // Error is raised so that it is visible in the first cycle with cyc > next_t.
                    if (fire_s && last_s) begin
                        state_d = ST_DONE;
                    end else if (cyc_inc_s > t_cand_s) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            cyc_q    <= {TW{1'b0}};
            idx_q    <= '0;
            next_t_q <= {TW{1'b0}};
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            idx_q    <= idx_d;
            next_t_q <= next_t_d;
            err_q    <= err_d;
        end
    end

    assign valid_o     = fire_s;
    assign ctrl_vars_o = idx_q;
    assign done_o      = (state_q == ST_DONE);
    assign sched_err_o = err_q;

endmodule

// File: tb/tb_affine_loop_controller.sv
// Self-checking bench: directed scenarios plus random configurations checked
// against a schedule list enumerated from the affine formula.
module tb_affine_loop_controller;
    localparam int DIMS = 3;
    localparam int IW   = 16;
    localparam int TW   = 32;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    flush;
    logic [DIMS-1:0][IW-1:0] extent;
    logic [DIMS-1:0][TW-1:0] stride;
    logic [TW-1:0]           start;
    logic                    valid;
    logic [DIMS-1:0][IW-1:0] ctrl;
    logic                    done;
    logic                    err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [TW-1:0]           m_t   [64];
    logic [DIMS-1:0][IW-1:0] m_idx [64];
    int                      m_n;

    affine_loop_controller #(.DIMS(DIMS), .IW(IW), .TW(TW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (flush),
        .extent_i       (extent),
        .sched_stride_i (stride),
        .sched_start_i  (start),
        .valid_o        (valid),
        .ctrl_vars_o    (ctrl),
        .done_o         (done),
        .sched_err_o    (err)
    );

    always #5 clk = ~clk;

    // Enumerate iterations in odometer order via mixed-radix decomposition.
    task automatic build_model();
        int e [DIMS];
        int rem;
        int dig;
        logic [TW-1:0] tt;
        m_n = 1;
        for (int d = 0; d < DIMS; d++) begin
            e[d] = (extent[d] == 0) ? 1 : int'(extent[d]);
            m_n  = m_n * e[d];
        end
        for (int n = 0; n < m_n; n++) begin
            rem = n;
            tt  = start;
            for (int d = DIMS - 1; d >= 0; d--) begin
                dig = rem % e[d];
                rem = rem / e[d];
                m_idx[n][d] = IW'(dig);
                tt = tt + TW'(dig) * stride[d];
            end
            m_t[n] = tt;
        end
    endtask

    task automatic run_case(input string name, input int flush_at, input int max_cyc,
                            output int pulses, output int first_fire, output int last_fire,
                            output int done_cyc);
        int k;
        int c;
        bit dm;
        bit em;
        bit flushed;
        logic ev;
        logic [DIMS-1:0][IW-1:0] ectrl;
        build_model();
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        k = 0; c = 0; dm = 0; em = 0; flushed = 0;
        pulses = 0; first_fire = -1; last_fire = -1; done_cyc = -1;
        while (c < max_cyc) begin
            @(negedge clk);
            if (!dm && (TW'(c) > m_t[k])) begin
                dm = 1; em = 1;
            end
            ev    = !dm && (TW'(c) == m_t[k]);
            ectrl = m_idx[k];
            n_checks += 4;
            if (valid !== ev) begin
                n_fail++;
                $display("FAIL %s valid c=%0d got=%b exp=%b", name, c, valid, ev);
            end
            if (ctrl !== ectrl) begin
                n_fail++;
                $display("FAIL %s ctrl_vars c=%0d got=%h exp=%h", name, c, ctrl, ectrl);
            end
            if (done !== dm) begin
                n_fail++;
                $display("FAIL %s done c=%0d got=%b exp=%b", name, c, done, dm);
            end
            if (err !== em) begin
                n_fail++;
                $display("FAIL %s sched_err c=%0d got=%b exp=%b", name, c, err, em);
            end
            if (valid === 1'b1) begin
                pulses++;
                if (first_fire < 0) first_fire = c;
                last_fire = c;
            end
            if (done === 1'b1 && done_cyc < 0) done_cyc = c;
            if (ev) begin
                if (k == m_n - 1) dm = 1;
                else k++;
            end
            if (c == flush_at && !flushed) begin
                flushed = 1;
                flush = 1'b1;
                @(posedge clk);
                #1 flush = 1'b0;
                k = 0; c = 0; dm = 0; em = 0;
                pulses = 0; first_fire = -1; last_fire = -1; done_cyc = -1;
            end else begin
                c++;
            end
        end
    endtask

    task automatic set_nominal();
        extent[0] = 16'd1; extent[1] = 16'd4; extent[2] = 16'd3;
        stride[0] = 32'd0; stride[1] = 32'd3; stride[2] = 32'd1;
        start     = 32'd5;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        extent = '0; stride = '0; start = 32'd0;
        #12;
        n_checks += 4;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL reset valid got=%b exp=0", valid); end
        if (ctrl !== '0)    begin n_fail++; $display("FAIL reset ctrl_vars got=%h exp=0", ctrl); end
        if (done !== 1'b0)  begin n_fail++; $display("FAIL reset done got=%b exp=0", done); end
        if (err !== 1'b0)   begin n_fail++; $display("FAIL reset sched_err got=%b exp=0", err); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (valid !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_no_fire valid=%b done=%b exp 0/0", valid, done);
            end
        end
    endtask

    task automatic test_nominal();
        int p, f, l, dc;
        set_nominal();
        run_case("nominal", -1, 22, p, f, l, dc);
        n_checks += 3;
        if (p != 12)  begin n_fail++; $display("FAIL nominal pulses got=%0d exp=12", p); end
        if (f != 5)   begin n_fail++; $display("FAIL nominal first got=%0d exp=5", f); end
        if (dc != 17) begin n_fail++; $display("FAIL nominal done_cycle got=%0d exp=17", dc); end
    endtask

    task automatic test_gapped();
        int p, f, l, dc;
        extent[0] = 16'd1; extent[1] = 16'd2; extent[2] = 16'd2;
        stride[0] = 32'd0; stride[1] = 32'd10; stride[2] = 32'd2;
        start     = 32'd0;
        run_case("gapped", -1, 18, p, f, l, dc);
        n_checks += 3;
        if (p != 4)   begin n_fail++; $display("FAIL gapped pulses got=%0d exp=4", p); end
        if (l != 12)  begin n_fail++; $display("FAIL gapped last got=%0d exp=12", l); end
        if (dc != 13) begin n_fail++; $display("FAIL gapped done_cycle got=%0d exp=13", dc); end
    endtask

    task automatic test_missed();
        int p, f, l, dc;
        extent[0] = 16'd1; extent[1] = 16'd1; extent[2] = 16'd3;
        stride = '0;
        start  = 32'd0;
        run_case("missed", -1, 8, p, f, l, dc);
        n_checks += 3;
        if (p != 1)  begin n_fail++; $display("FAIL missed pulses got=%0d exp=1", p); end
        if (dc != 1) begin n_fail++; $display("FAIL missed done_cycle got=%0d exp=1", dc); end
        if (err !== 1'b1) begin n_fail++; $display("FAIL missed sticky_err got=%b exp=1", err); end
    endtask

    task automatic test_flush_mid_run();
        int p, f, l, dc;
        set_nominal();
        run_case("flush_mid", 9, 22, p, f, l, dc);
        n_checks += 3;
        if (p != 12)  begin n_fail++; $display("FAIL flush_mid pulses got=%0d exp=12", p); end
        if (f != 5)   begin n_fail++; $display("FAIL flush_mid first got=%0d exp=5", f); end
        if (dc != 17) begin n_fail++; $display("FAIL flush_mid done_cycle got=%0d exp=17", dc); end
    endtask

    task automatic test_reset_mid_run();
        set_nominal();
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        repeat (8) @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid pre_valid got=%b exp=1", valid); end
        #1 rst_n = 1'b0;
        #1;
        n_checks += 4;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid valid got=%b exp=0", valid); end
        if (ctrl !== '0)    begin n_fail++; $display("FAIL rst_mid ctrl_vars got=%h exp=0", ctrl); end
        if (done !== 1'b0)  begin n_fail++; $display("FAIL rst_mid done got=%b exp=0", done); end
        if (err !== 1'b0)   begin n_fail++; $display("FAIL rst_mid sched_err got=%b exp=0", err); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (valid !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid post_idle valid=%b done=%b exp 0/0", valid, done);
            end
        end
    endtask

    task automatic test_degenerate();
        int p, f, l, dc;
        extent = '0;
        stride[0] = 32'd7; stride[1] = 32'd9; stride[2] = 32'd11;
        start  = 32'd3;
        run_case("degenerate", -1, 8, p, f, l, dc);
        n_checks += 3;
        if (p != 1)  begin n_fail++; $display("FAIL degenerate pulses got=%0d exp=1", p); end
        if (f != 3)  begin n_fail++; $display("FAIL degenerate first got=%0d exp=3", f); end
        if (dc != 4) begin n_fail++; $display("FAIL degenerate done_cycle got=%0d exp=4", dc); end
    endtask

    task automatic test_back_to_back();
        int p, f, l, dc;
        extent[0] = 16'd2; extent[1] = 16'd2; extent[2] = 16'd2;
        stride[0] = 32'd4; stride[1] = 32'd2; stride[2] = 32'd1;
        start     = 32'd1;
        run_case("back_to_back", -1, 12, p, f, l, dc);
        n_checks += 2;
        if (p != 8) begin n_fail++; $display("FAIL back_to_back pulses got=%0d exp=8", p); end
        if ((l - f + 1) != 8) begin
            n_fail++;
            $display("FAIL back_to_back span got=%0d exp=8", l - f + 1);
        end
    endtask

    task automatic test_random();
        int p, f, l, dc;
        for (int it = 0; it < 20; it++) begin
            for (int d = 0; d < DIMS; d++) begin
                extent[d] = IW'($urandom_range(0, 3));
                stride[d] = TW'($urandom_range(0, 4));
            end
            start = TW'($urandom_range(0, 8));
            run_case("random", -1, 45, p, f, l, dc);
            n_checks++;
            if (dc < 0) begin n_fail++; $display("FAIL random done_seen got=%0d exp>=0", dc); end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_gapped();
        test_missed();
        test_flush_mid_run();
        test_reset_mid_run();
        test_degenerate();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
